// File: rtl/seg_pkg.sv
// Shared helpers and types for the seven-segment scan multiplexer.
package seg_pkg;

    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic logic [63:0] ones(input int width);
        return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    endfunction

    localparam int SEG_N        = 7;
    localparam int SEG_CHANNELS = 4;

    // Active-low segments: all ones turns every segment off.
    localparam logic [SEG_N-1:0] SEG_BLANK = SEG_N'(ones(SEG_N));

    typedef logic [clog2_min1(SEG_CHANNELS)-1:0] slot_idx_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 while enabled and pulses tick_o on the last count.
module seg_tick_gen
    import seg_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = clog2_min1(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Round-robin seven-segment scan multiplexer with hold (plain-mux) mode.
// Optional ghosting guard enabled by defining SEG_SCAN_GUARD_EN.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int N        = 7,
    parameter int CHANNELS = 4,
    parameter int DIV      = 100000
`ifdef SEG_SCAN_GUARD_EN
    , parameter int GUARD  = 2
`endif
    , localparam int SW    = clog2_min1(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [CHANNELS*N-1:0] data_in,
    input  logic [CHANNELS-1:0]   blank,
    input  logic                  hold,
    input  logic [SW-1:0]         hold_sel,
    output logic [N-1:0]          seg_out,
    output logic [CHANNELS-1:0]   an_out,
    output logic [SW-1:0]         slot,
    output logic                  frame_tick
);

    localparam logic [N-1:0] BLANK_WORD = (N == SEG_N) ? N'(SEG_BLANK) : N'(ones(N));

    logic [SW-1:0]       slot_q, slot_d;
    logic [N-1:0]        seg_q, seg_d;
    logic [CHANNELS-1:0] an_q, an_d;
    logic                ft_q, ft_d;
    logic                run, tick, last_slot, visible;

    // Hold parks the prescaler at 0 so release starts a full slot.
    assign run       = en && !hold;
    assign last_slot = (int'(slot_q) == CHANNELS - 1);

    seg_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (run),
        .clr_i  (!run),
        .tick_o (tick)
    );

`ifdef SEG_SCAN_GUARD_EN
    localparam int AW = clog2_min1(GUARD + 1);

    logic [AW-1:0] age_q, age_d;
    logic          held_q;

    // Cycles since the current slot began; saturates once past the guard window.
    always_comb begin
        age_d = age_q;
        if (!en || tick || (hold != held_q)) begin
            age_d = '0;
        end else if (int'(age_q) < GUARD) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q  <= '0;
            held_q <= 1'b0;
        end else begin
            age_q  <= age_d;
            held_q <= en && hold;
        end
    end
`endif

    always_comb begin
        slot_d = slot_q;
        if (!en) begin
            slot_d = '0;
        end else if (hold) begin
            slot_d = (int'(hold_sel) < CHANNELS) ? hold_sel : '0;
        end else if (tick) begin
            slot_d = last_slot ? '0 : slot_q + 1'b1;
        end
    end

    assign ft_d    = tick && last_slot;
    assign visible = en && !blank[slot_q];

    always_comb begin
        seg_d = BLANK_WORD;
        an_d  = '1;
        if (visible) begin
            seg_d = data_in[slot_q*N +: N];
            an_d  = ~(CHANNELS'(1) << slot_q);
        end
`ifdef SEG_SCAN_GUARD_EN
        // The new word is already on the segments; only the enable waits out the guard.
        if (int'(age_q) < GUARD) begin
            an_d = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            seg_q  <= BLANK_WORD;
            an_q   <= '1;
            ft_q   <= 1'b0;
        end else begin
            slot_q <= slot_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            ft_q   <= ft_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign slot       = slot_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: cycle model plus directed literal checks.
module tb_seg_scan_mux;

    localparam int N  = 7;
    localparam int CH = 4;
    localparam int DV = 4;
`ifdef SEG_SCAN_GUARD_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en, hold;
    logic [27:0]   data_in;
    logic [3:0]    blank;
    logic [1:0]    hold_sel;
    logic [6:0]    seg_out;
    logic [3:0]    an_out;
    logic [1:0]    slot;
    logic          frame_tick;

    logic [20:0]   data3;
    logic [2:0]    blank3;
    logic          hold3;
    logic [1:0]    hold_sel3;
    logic [6:0]    seg3;
    logic [2:0]    an3;
    logic [1:0]    slot3;
    logic          ft3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.N(N), .CHANNELS(CH), .DIV(DV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .blank(blank),
        .hold(hold), .hold_sel(hold_sel), .seg_out(seg_out), .an_out(an_out),
        .slot(slot), .frame_tick(frame_tick)
    );

    seg_scan_mux #(.N(N), .CHANNELS(3), .DIV(DV)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(data3), .blank(blank3),
        .hold(hold3), .hold_sel(hold_sel3), .seg_out(seg3), .an_out(an3),
        .slot(slot3), .frame_tick(ft3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: slot index and position within the slot as plain integers.
    int         m_slot, m_phase, m_age;
    logic       m_held;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic [1:0] e_slot;
    logic       e_ft;

    always @(posedge clk or negedge rst_n) begin : model
        int  ns, np, na;
        bit  vis, adv;
        if (!rst_n) begin
            m_slot  <= 0;
            m_phase <= 0;
            m_age   <= 0;
            m_held  <= 1'b0;
            e_seg   <= 7'h7F;
            e_an    <= 4'hF;
            e_slot  <= 2'd0;
            e_ft    <= 1'b0;
        end else begin
            vis = en && !blank[m_slot];
            adv = en && !hold && (m_phase == DV - 1);
            e_seg <= vis ? data_in[m_slot*N +: N] : 7'h7F;
            e_an  <= (vis && m_age >= G) ? (4'hF ^ (4'h1 << m_slot)) : 4'hF;
            e_ft  <= adv && (m_slot == CH - 1);
            if (!en) begin
                ns = 0; np = 0;
            end else if (hold) begin
                ns = (int'(hold_sel) < CH) ? int'(hold_sel) : 0; np = 0;
            end else if (adv) begin
                ns = (m_slot + 1) % CH; np = 0;
            end else begin
                ns = m_slot; np = m_phase + 1;
            end
            if (!en || adv || (hold != m_held)) na = 0;
            else na = (m_age < G) ? m_age + 1 : m_age;
            m_slot  <= ns;
            m_phase <= np;
            m_age   <= na;
            m_held  <= en && hold;
            e_slot  <= ns[1:0];
        end
    end

    always @(negedge clk) begin
        check("model_seg", {25'd0, seg_out}, {25'd0, e_seg});
        check("model_an", {28'd0, an_out}, {28'd0, e_an});
        check("model_slot", {30'd0, slot}, {30'd0, e_slot});
        check("model_ft", {31'd0, frame_tick}, {31'd0, e_ft});
    end

    function automatic logic [3:0] gmask(input int k, input logic [3:0] a);
        return (((k - 1) % DV) < G) ? 4'hF : a;
    endfunction

    logic [3:0] an_h [1:32];
    logic [6:0] seg_h[1:32];
    logic [1:0] slot_h[1:32];
    logic       ft_h [1:32];

    task automatic record(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            an_h[k]   = an_out;
            seg_h[k]  = seg_out;
            slot_h[k] = slot;
            ft_h[k]   = frame_tick;
        end
    endtask

    initial begin
        int cnt;
        en = 1'b0; hold = 1'b0; hold_sel = 2'd0; blank = 4'b0000;
        data_in = {7'h08, 7'h04, 7'h02, 7'h01};
        data3 = {7'h04, 7'h02, 7'h01}; blank3 = 3'b000; hold3 = 1'b0; hold_sel3 = 2'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_seg", {25'd0, seg_out}, 32'h7F);
        check("reset_an", {28'd0, an_out}, 32'hF);
        check("reset_slot", {30'd0, slot}, 32'd0);
        check("reset_ft", {31'd0, frame_tick}, 32'd0);

        // Scan
        rst_n = 1'b1; en = 1'b1;
        record(32);
        check("scan_an1", {28'd0, an_h[1]}, {28'd0, gmask(1, 4'b1110)});
        check("scan_an4", {28'd0, an_h[4]}, {28'd0, gmask(4, 4'b1110)});
        check("scan_an5", {28'd0, an_h[5]}, {28'd0, gmask(5, 4'b1101)});
        check("scan_an9", {28'd0, an_h[9]}, {28'd0, gmask(9, 4'b1011)});
        check("scan_an13", {28'd0, an_h[13]}, {28'd0, gmask(13, 4'b0111)});
        check("scan_an16", {28'd0, an_h[16]}, {28'd0, gmask(16, 4'b0111)});
        check("scan_an17", {28'd0, an_h[17]}, {28'd0, gmask(17, 4'b1110)});
        check("scan_seg1", {25'd0, seg_h[1]}, 32'h01);
        check("scan_seg4_lag", {25'd0, seg_h[4]}, 32'h01);
        check("scan_seg5", {25'd0, seg_h[5]}, 32'h02);
        check("scan_seg16", {25'd0, seg_h[16]}, 32'h08);
        check("scan_slot3", {30'd0, slot_h[3]}, 32'd0);
        check("scan_slot4", {30'd0, slot_h[4]}, 32'd1);
        check("scan_slot16", {30'd0, slot_h[16]}, 32'd0);
        check("scan_ft15", {31'd0, ft_h[15]}, 32'd0);
        check("scan_ft16", {31'd0, ft_h[16]}, 32'd1);
        check("scan_ft32", {31'd0, ft_h[32]}, 32'd1);
        cnt = 0;
        for (int k = 1; k <= 32; k++) cnt += int'(ft_h[k]);
        check("scan_ft_count", cnt, 32'd2);

        // Blank channel 2
        blank = 4'b0100;
        record(16);
        cnt = 0;
        for (int k = 1; k <= 16; k++) cnt += (an_h[k] == 4'hF) ? 1 : 0;
        check("blank_an_off_count", cnt, 4 + 3 * G);
        check("blank_seg10", {25'd0, seg_h[10]}, 32'h7F);
        check("blank_seg5", {25'd0, seg_h[5]}, 32'h02);
        cnt = 0;
        for (int k = 1; k <= 16; k++) cnt += int'(ft_h[k]);
        check("blank_ft_count", cnt, 32'd1);
        check("blank_ft16", {31'd0, ft_h[16]}, 32'd1);
        blank = 4'b0000;

        // Hold on channel 3 entered mid-slot 1
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_pre_slot", {30'd0, slot}, 32'd1);
        hold = 1'b1; hold_sel = 2'd3;
        @(negedge clk);
        check("hold_slot", {30'd0, slot}, 32'd3);
        record(32);
        cnt = 0;
        for (int k = 1; k <= 32; k++) cnt += (an_h[k] == 4'b0111) ? 1 : 0;
        check("hold_an_count_a", cnt, 32 - G);
        cnt = 0;
        for (int k = 1; k <= 32; k++) cnt += int'(ft_h[k]);
        record(18);
        for (int k = 1; k <= 18; k++) cnt += int'(ft_h[k]) + ((an_h[k] != 4'b0111) ? 1 : 0);
        check("hold_no_ft_steady_an", cnt, 32'd0);
        data_in[21 +: 7] = 7'h55;
        @(negedge clk);
        check("hold_seg_update", {25'd0, seg_out}, 32'h55);
        hold = 1'b0;
        record(4);
        check("release_slot1", {30'd0, slot_h[1]}, 32'd3);
        check("release_slot3", {30'd0, slot_h[3]}, 32'd3);
        check("release_ft3", {31'd0, ft_h[3]}, 32'd0);
        check("release_slot4", {30'd0, slot_h[4]}, 32'd0);
        check("release_ft4", {31'd0, ft_h[4]}, 32'd1);
        data_in[21 +: 7] = 7'h08;

        // Enable drop mid-slot 2
        repeat (9) @(negedge clk);
        check("en_pre_slot", {30'd0, slot}, 32'd2);
        en = 1'b0;
        @(negedge clk);
        check("en_off_an", {28'd0, an_out}, 32'hF);
        check("en_off_seg", {25'd0, seg_out}, 32'h7F);
        check("en_off_slot", {30'd0, slot}, 32'd0);
        en = 1'b1;
        record(4);
        check("reen_slot3", {30'd0, slot_h[3]}, 32'd0);
        check("reen_slot4", {30'd0, slot_h[4]}, 32'd1);

        // Asynchronous reset between edges
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_seg", {25'd0, seg_out}, 32'h7F);
        check("async_an", {28'd0, an_out}, 32'hF);
        check("async_slot", {30'd0, slot}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Out-of-range hold on the three-channel instance
        hold3 = 1'b1; hold_sel3 = 2'd3;
        repeat (2 + G) @(negedge clk);
        check("oor_slot", {30'd0, slot3}, 32'd0);
        check("oor_an", {29'd0, an3}, 32'b110);
        check("oor_seg", {25'd0, seg3}, 32'h01);
        hold_sel3 = 2'd2;
        repeat (2) @(negedge clk);
        check("hold3_an", {29'd0, an3}, 32'b011);
        check("hold3_seg", {25'd0, seg3}, 32'h04);
        check("hold3_ft", {31'd0, ft3}, 32'd0);
        hold3 = 1'b0;

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
